instr_encoder: RTL and testbench
================================

# instr_encoder

Encodes structured instruction requests into 32-bit ARM-subset machine words, the inverse of the processor's instruction decode path. Accepted words go into a 2-entry output queue and leave with a sequential word address. The block sits between the test/program-generation front end and the instruction-memory write port, so programs can be built from fields rather than hand-assembled hex. Illegal requests are rejected and counted, and are never emitted.

## Interface
Parameters:
- ADDR_W, 8, width of the word address counter.

Ports:
- clk  in  1  the single clock; every register is clocked on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- flush  in  1  synchronous clear of the queue and the address counter.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- kind  in  2  request kind: 00 = data-processing, 01 = memory, 10 = branch, 11 = illegal.
- cond  in  4  condition field, placed at instr[31:28].
- cmd  in  4  data-processing command.
- s_bit  in  1  set-flags request (data-processing only).
- imm_sel  in  1  1 = immediate Src2, 0 = register Src2.
- load  in  1  memory kind only: 1 = LDR, 0 = STR.
- rn, rd, rm  in  4 each  register numbers.
- imm12  in  12  {rot4, imm8} for data-processing; unsigned offset for memory.
- imm24  in  24  branch offset.
- out_valid  out  1  head of queue valid.
- out_ready  in  1  consumer takes the head.
- out_instr  out  32  encoded word.
- out_addr  out  ADDR_W  word address assigned to out_instr.
- err  out  1  one-cycle pulse on a rejected request.
- err_count  out  8  rejected-request count, saturates at 255.

## Operation
- The request handshake completes when in_valid && in_ready. The output handshake completes when out_valid && out_ready.
- Data-processing (kind 00):
  - instr = {cond, 2'b00, imm_sel, cmd, S, rn, rd, src2}.
  - src2 = imm12 when imm_sel = 1, otherwise {8'b0, rm}.
  - Legal cmd values: AND 0000, SUB 0010, ADD 0100, ORR 1100, CMP 1010.
  - For CMP, S is forced to 1 and the Rd field is forced to 0. For all other legal commands, S = s_bit.
- Memory (kind 01):
  - instr = {cond, 2'b01, ~imm_sel, 1'b1, 1'b1, 1'b0, 1'b0, load, rn, rd, src2}. This sets P=1, U=1, B=0, W=0.
  - src2 = imm12 when imm_sel = 1, otherwise {8'b0, rm}.
- Branch (kind 10): instr = {cond, 4'b1010, imm24}.
- Rejection:
  - A request is rejected when kind = 11, or when kind = 00 with a cmd outside the legal set.
  - A rejected request still completes its handshake and is consumed.
  - On rejection: err pulses, err_count increments, nothing is queued, and the address does not advance.
- Queue:
  - 2-entry FIFO of {instr, addr}.
  - The address counter is the address for the next accepted legal request. It increments by 1 on each legal accept and wraps from 2^ADDR_W−1 to 0.
- Flush:
  - Empties the queue, clears the address counter to 0 and drops any pending err pulse. err_count is preserved.
  - A request presented in the same cycle as flush is ignored, even though in_ready may be 1.
- Reset values: queue empty, out_valid=0, out_instr=0, out_addr=0, address counter=0, err=0, err_count=0.

## Timing
- in_ready = (queue occupancy < 2) && !flush. It is combinational from registered state and flush only, and never depends on out_ready. There is no pass-through when full.
- Latency: a legal request accepted in cycle N appears at out_valid/out_instr in cycle N+1 if the queue was empty, otherwise behind the older entry.
- A rejected request accepted in cycle N produces err=1 in cycle N+1 only.
- Simultaneous push and pop when occupancy is 1: occupancy stays 1, the new entry becomes head after the pop, and order is preserved.
- The output holds stable while out_valid && !out_ready.
- Asserting rst_n low mid-transfer clears everything immediately. Queued entries are lost, and the first post-reset request gets address 0.
- All outputs are registered or come directly from the queue storage. out_valid, out_instr and out_addr have no combinational path from the request inputs.

## Test plan
- ADD with cond=1110, imm_sel=1, rn=1, rd=2, imm12=0x005, s_bit=0 -> out_instr=0xE2812005, out_addr=0 one cycle after accept.
- LDR with cond=1110, imm_sel=1, rn=0, rd=3, imm12=0x004, then STR with rn=0, rd=3, imm12=0x008 -> 0xE5903004 at addr 0, then 0xE5803008 at addr 1.
- CMP with cond=1110, imm_sel=0, rn=4, rd=7, rm=5, s_bit=0 -> 0xE1540005 (S forced to 1, Rd forced to 0). Then a branch with cond=0000, imm24=0xFFFFFE -> 0x0AFFFFFE.
- Hold out_ready=0 and send 3 requests -> in_ready drops after 2 accepts. Then assert out_ready -> entries drain in order with addresses 0 and 1, and the third request is accepted with address 2.
- Send kind=11, then cmd=0001 -> err pulses twice, err_count=2, no output, and the next legal request gets address 0. Repeat 300 rejected requests -> err_count holds at 255.
- Queue 2 entries, then assert flush together with a valid request -> queue empty, the request is ignored, and the next legal request gets address 0. Drive address past 255 -> it wraps to 0. Assert rst_n low mid-stream -> all outputs return to their reset values.

Source files
------------

// File: rtl/instr_encoder.sv
// Field-to-word encoder for the ARM-subset instruction format.
// Legal words land in a 2-entry queue tagged with a sequential word address.
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        kind,
  input  logic [3:0]        cond,
  input  logic [3:0]        cmd,
  input  logic              s_bit,
  input  logic              imm_sel,
  input  logic              load,
  input  logic [3:0]        rn,
  input  logic [3:0]        rd,
  input  logic [3:0]        rm,
  input  logic [11:0]       imm12,
  input  logic [23:0]       imm24,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [7:0]        err_count
);

  logic [1:0]        cnt;
  logic [31:0]       tl_instr;
  logic [ADDR_W-1:0] tl_addr;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       word;
  logic [11:0]       src2;
  logic              legal;
  logic              is_cmp;
  logic              accept;
  logic              push;
  logic              pop;

  assign in_ready  = (cnt != 2'd2) && !flush;
  assign out_valid = (cnt != 2'd0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign pop       = out_valid && out_ready;
  assign src2      = imm_sel ? imm12 : {8'b0, rm};
  assign is_cmp    = (cmd == 4'b1010);

  always_comb begin
    legal = 1'b0;
    word  = '0;
    unique case (1'b1)
      kind == 2'b00: begin
        legal = (cmd == 4'b0000) || (cmd == 4'b0010) ||
                (cmd == 4'b0100) || (cmd == 4'b1100) || is_cmp;
        word  = {cond, 2'b00, imm_sel, cmd, s_bit | is_cmp,
                 rn, is_cmp ? 4'b0 : rd, src2};
      end
      kind == 2'b01: begin
        legal = 1'b1;
        word  = {cond, 2'b01, ~imm_sel, 1'b1, 1'b1, 1'b0,
                 1'b0, load, rn, rd, src2};
      end
      kind == 2'b10: begin
        legal = 1'b1;
        word  = {cond, 4'b1010, imm24};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      addr      <= '0;
      out_instr <= '0;
      out_addr  <= '0;
      tl_instr  <= '0;
      tl_addr   <= '0;
      err       <= 1'b0;
      err_count <= '0;
    end else if (flush) begin
      cnt  <= '0;
      addr <= '0;
      err  <= 1'b0;
    end else begin
      err <= accept && !legal;
      if (accept && !legal && err_count != 8'hff)
        err_count <= err_count + 8'd1;
      if (push)
        addr <= addr + 1'b1;
      unique case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) begin
            out_instr <= word;
            out_addr  <= addr;
          end else begin
            tl_instr <= word;
            tl_addr  <= addr;
          end
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          out_instr <= tl_instr;
          out_addr  <= tl_addr;
          cnt       <= cnt - 2'd1;
        end
        // push+pop only happens at occupancy 1
        2'b11: begin
          out_instr <= word;
          out_addr  <= addr;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed requests,
// expected words queued at accept, checked as the DUT emits them.
module tb_instr_encoder;

  typedef struct packed {
    logic [31:0] instr;
    logic [7:0]  addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  kind = '0;
  logic [3:0]  cond = '0;
  logic [3:0]  cmd = '0;
  logic        s_bit = 1'b0;
  logic        imm_sel = 1'b0;
  logic        load = 1'b0;
  logic [3:0]  rn = '0;
  logic [3:0]  rd = '0;
  logic [3:0]  rm = '0;
  logic [11:0] imm12 = '0;
  logic [23:0] imm24 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [7:0]  out_addr;
  logic        err;
  logic [7:0]  err_count;

  exp_t        sb[$];
  logic [7:0]  exp_addr = '0;
  logic [7:0]  exp_cnt = '0;
  int          exp_pulses = 0;
  int          pulses = 0;
  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] held;

  instr_encoder #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .kind(kind), .cond(cond), .cmd(cmd),
    .s_bit(s_bit), .imm_sel(imm_sel), .load(load),
    .rn(rn), .rd(rd), .rm(rm),
    .imm12(imm12), .imm24(imm24),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (err) pulses++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_out: got %0h at %0h expected none",
                   out_instr, out_addr);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_instr", {32'b0, out_instr}, {32'b0, e.instr});
          chk("out_addr", {56'b0, out_addr}, {56'b0, e.addr});
        end
      end
    end
  end

  task automatic req(input logic [1:0] k, input logic [3:0] c,
                     input logic [3:0] cm, input logic s,
                     input logic is, input logic ld,
                     input logic [3:0] n, input logic [3:0] d,
                     input logic [3:0] m, input logic [11:0] i12,
                     input logic [23:0] i24, input logic [31:0] e,
                     input logic lg);
    int w;
    kind = k; cond = c; cmd = cm; s_bit = s; imm_sel = is;
    load = ld; rn = n; rd = d; rm = m; imm12 = i12; imm24 = i24;
    in_valid = 1'b1;
    w = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      w++;
      if (w > 100) begin
        compared++;
        mismatched++;
        $display("FAIL accept_timeout: got in_ready=0 expected 1");
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (lg) begin
      sb.push_back({e, exp_addr});
      exp_addr++;
    end else begin
      exp_pulses++;
      exp_cnt = (exp_cnt == 8'hff) ? 8'hff : exp_cnt + 8'd1;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #12;
    chk("rst_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_instr", {32'b0, out_instr}, 64'd0);
    chk("rst_addr", {56'b0, out_addr}, 64'd0);
    chk("rst_err", {63'b0, err}, 64'd0);
    chk("rst_errcnt", {56'b0, err_count}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);

    // ADD r2, r1, #5
    req(2'b00, 4'hE, 4'b0100, 0, 1, 0, 4'd1, 4'd2, 4'd0, 12'h005,
        24'h0, 32'hE2812005, 1);
    chk("latency_valid", {63'b0, out_valid}, 64'd1);
    chk("latency_instr", {32'b0, out_instr}, 64'hE2812005);
    // LDR / STR
    req(2'b01, 4'hE, 4'h0, 0, 1, 1, 4'd0, 4'd3, 4'd0, 12'h004,
        24'h0, 32'hE5903004, 1);
    req(2'b01, 4'hE, 4'h0, 0, 1, 0, 4'd0, 4'd3, 4'd0, 12'h008,
        24'h0, 32'hE5803008, 1);
    // CMP r4, r5 and branch
    req(2'b00, 4'hE, 4'b1010, 0, 0, 0, 4'd4, 4'd7, 4'd5, 12'h0,
        24'h0, 32'hE1540005, 1);
    req(2'b10, 4'h0, 4'h0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 12'h0,
        24'hFFFFFE, 32'h0AFFFFFE, 1);
    // ORR with S, register src2
    req(2'b00, 4'h1, 4'b1100, 1, 0, 0, 4'd9, 4'd8, 4'd6, 12'h0,
        24'h0, 32'h11998006, 1);
    wait_drain();

    // backpressure
    out_ready = 1'b0;
    req(2'b00, 4'hE, 4'b0000, 0, 1, 0, 4'd1, 4'd1, 4'd0, 12'h0FF,
        24'h0, 32'hE20110FF, 1);
    req(2'b00, 4'hE, 4'b0010, 1, 1, 0, 4'd2, 4'd3, 4'd0, 12'h001,
        24'h0, 32'hE2523001, 1);
    chk("full_in_ready", {63'b0, in_ready}, 64'd0);
    held = out_instr;
    fork
      req(2'b10, 4'hE, 4'h0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 12'h0,
          24'h000010, 32'hEA000010, 1);
      begin
        repeat (4) @(posedge clk);
        #1;
        chk("hold_instr", {32'b0, out_instr}, {32'b0, held});
        chk("stall_in_ready", {63'b0, in_ready}, 64'd0);
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // rejections
    req(2'b11, 4'hE, 4'h0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 12'h0,
        24'h0, 32'h0, 0);
    req(2'b00, 4'hE, 4'b0001, 0, 0, 0, 4'd0, 4'd0, 4'd0, 12'h0,
        24'h0, 32'h0, 0);
    @(posedge clk);
    #1;
    chk("err_count2", {56'b0, err_count}, 64'd2);
    chk("err_pulses", 64'(pulses), 64'(exp_pulses));
    chk("err_low", {63'b0, err}, 64'd0);
    chk("rej_no_out", {63'b0, out_valid}, 64'd0);
    req(2'b01, 4'h0, 4'h0, 0, 0, 1, 4'd5, 4'd6, 4'd7, 12'h0,
        24'h0, 32'h07956007, 1);
    wait_drain();
    for (int i = 0; i < 300; i++)
      req(2'b11, 4'h0, 4'h0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 12'h0,
          24'h0, 32'h0, 0);
    @(posedge clk);
    #1;
    chk("err_sat", {56'b0, err_count}, 64'd255);
    chk("err_model", {56'b0, err_count}, {56'b0, exp_cnt});
    chk("err_pulses300", 64'(pulses), 64'(exp_pulses));

    // flush with a colliding request
    out_ready = 1'b0;
    req(2'b10, 4'hE, 4'h0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 12'h0,
        24'h000001, 32'hEA000001, 1);
    req(2'b10, 4'hE, 4'h0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 12'h0,
        24'h000002, 32'hEA000002, 1);
    kind = 2'b10; imm24 = 24'h000003;
    in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", {63'b0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    exp_addr = '0;
    chk("flush_valid", {63'b0, out_valid}, 64'd0);
    chk("flush_errcnt", {56'b0, err_count}, 64'd255);
    out_ready = 1'b1;
    req(2'b10, 4'hE, 4'h0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 12'h0,
        24'h000004, 32'hEA000004, 1);
    wait_drain();

    // address wrap
    for (int i = 0; i < 256; i++) begin
      logic [23:0] v;
      v = 24'(i);
      req(2'b10, 4'hE, 4'h0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 12'h0,
          v, {8'hEA, v}, 1);
    end
    wait_drain();

    // reset mid-stream
    out_ready = 1'b0;
    req(2'b10, 4'h3, 4'h0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 12'h0,
        24'h00000A, 32'h3A00000A, 1);
    req(2'b10, 4'h3, 4'h0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 12'h0,
        24'h00000B, 32'h3A00000B, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {63'b0, out_valid}, 64'd0);
    chk("mid_rst_instr", {32'b0, out_instr}, 64'd0);
    chk("mid_rst_addr", {56'b0, out_addr}, 64'd0);
    chk("mid_rst_err", {63'b0, err}, 64'd0);
    chk("mid_rst_errcnt", {56'b0, err_count}, 64'd0);
    sb.delete();
    exp_addr = '0;
    exp_cnt = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    req(2'b00, 4'hE, 4'b0100, 0, 1, 0, 4'd1, 4'd2, 4'd0, 12'h005,
        24'h0, 32'hE2812005, 1);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
